// File: rtl/prison_perm_loader.sv
// Seeded Fisher-Yates permutation generator that streams slips 1..N into the prison box top's load port.
// Optional build macro PERM_CHECK_EN adds a used-value bitmap that flags repeated or out-of-range data.
module prison_perm_loader #(
    parameter int          N            = 100,
    parameter int          LFSR_W       = 16,
    parameter logic [31:0] BOX_KEY      = 32'hDEADBEEF,
    parameter logic [31:0] PRISONER_KEY = 32'hCAFEFACE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              load_boxes_o,
    output logic              load_prisoners_o,
    output logic [7:0]        select_o,
    output logic [7:0]        data_o,
    output logic [31:0]       guard_key_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              perm_err_o,
    output logic [2:0]        state_o
);
    localparam int IW = $clog2(N);
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT = LFSR_W'(16'hACE1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_SHUFFLE  = 3'd2;
    localparam logic [2:0] S_EMIT_ON  = 3'd3;
    localparam logic [2:0] S_EMIT_OFF = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [IW-1:0]     k_q, k_d;
    logic [IW-1:0]     i_q, i_d;
    logic [7:0]        arr_q [N];

    logic [IW-1:0] r;
    logic          take;
    logic          emit;
    logic          lfsr_fb;

    assign r       = lfsr_q[IW-1:0];
    assign take    = (r <= i_q);
    assign emit    = (state_q == S_EMIT_ON);
    assign lfsr_fb = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-3] ^ lfsr_q[LFSR_W-4] ^ lfsr_q[LFSR_W-6];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        k_d     = k_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    lfsr_d  = (seed_i == '0) ? LFSR_DEFAULT : seed_i;
                    k_d     = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (k_q == IW'(N - 1)) begin
                    k_d     = '0;
                    i_d     = IW'(N - 1);
                    state_d = S_SHUFFLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_SHUFFLE: begin
                lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
                // Accepting the swap at i==1 completes the shuffle; slot 0 never needs a draw.
                if (take) begin
                    i_d = i_q - 1'b1;
                    if (i_q == IW'(1)) state_d = S_EMIT_ON;
                end
            end
            S_EMIT_ON: state_d = S_EMIT_OFF;
            S_EMIT_OFF: begin
                if (k_q == IW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_EMIT_ON;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            lfsr_q  <= LFSR_DEFAULT;
            k_q     <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            k_q     <= k_d;
            i_q     <= i_d;
        end
    end

    // Permutation storage is never reset; INIT rebuilds it on every run.
    always_ff @(posedge clk_i) begin
        if (state_q == S_INIT) begin
            arr_q[k_q] <= 8'(k_q) + 8'd1;
        end else if (state_q == S_SHUFFLE && take) begin
            arr_q[i_q] <= arr_q[r];
            arr_q[r]   <= arr_q[i_q];
        end
    end

    assign load_boxes_o     = emit & ~mode_q;
    assign load_prisoners_o = emit & mode_q;
    assign select_o         = emit ? 8'(k_q) : 8'd0;
    assign data_o           = emit ? arr_q[k_q] : 8'd0;
    assign guard_key_o      = emit ? (mode_q ? PRISONER_KEY : BOX_KEY) : 32'd0;
    assign busy_o           = (state_q == S_INIT) || (state_q == S_SHUFFLE) ||
                              (state_q == S_EMIT_ON) || (state_q == S_EMIT_OFF);
    assign done_o           = (state_q == S_DONE);
    assign state_o          = state_q;

`ifdef PERM_CHECK_EN
    logic [N-1:0] used_q;
    logic         perm_err_q;
    logic [7:0]   didx;

    assign didx = data_o - 8'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            used_q     <= '0;
            perm_err_q <= 1'b0;
        end else if (state_q == S_IDLE && start_i) begin
            used_q     <= '0;
            perm_err_q <= 1'b0;
        end else if (emit) begin
            if (data_o == 8'd0 || data_o > 8'(N)) begin
                perm_err_q <= 1'b1;
            end else begin
                if (used_q[didx[IW-1:0]]) perm_err_q <= 1'b1;
                used_q[didx[IW-1:0]] <= 1'b1;
            end
        end
    end

    assign perm_err_o = perm_err_q;
`else
    assign perm_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prison_perm_loader.sv
// Directed bench for prison_perm_loader: reset, box/prisoner loads, seed aliasing, ignored starts, mid-run reset.
module tb_prison_perm_loader;
    localparam int N = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] seed = 16'd0;
    logic        load_boxes, load_prisoners, busy, done, perm_err;
    logic [7:0]  select_v, data_v;
    logic [31:0] guard_key;
    logic [2:0]  state_v;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] ref_q[$];

    prison_perm_loader #(.N(N)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .mode_i           (mode),
        .seed_i           (seed),
        .load_boxes_o     (load_boxes),
        .load_prisoners_o (load_prisoners),
        .select_o         (select_v),
        .data_o           (data_v),
        .guard_key_o      (guard_key),
        .busy_o           (busy),
        .done_o           (done),
        .perm_err_o       (perm_err),
        .state_o          (state_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " load_boxes"}, {31'd0, load_boxes}, 32'd0);
        check({tag, " load_prisoners"}, {31'd0, load_prisoners}, 32'd0);
        check({tag, " select"}, {24'd0, select_v}, 32'd0);
        check({tag, " data"}, {24'd0, data_v}, 32'd0);
        check({tag, " guard_key"}, guard_key, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " perm_err"}, {31'd0, perm_err}, 32'd0);
    endtask

    // Reference Fisher-Yates over the specified LFSR: one draw per cycle, reject draws above i.
    task automatic build_exp(input logic [15:0] s);
        logic [15:0] l;
        logic [7:0]  a [N];
        logic [7:0]  tmp;
        int          i;
        int          r;
        int          guard;
        l = (s == 16'd0) ? 16'hACE1 : s;
        for (int k = 0; k < N; k++) a[k] = 8'(k + 1);
        i = N - 1;
        guard = 0;
        while (i > 0 && guard < 100000) begin
            r = int'(l[6:0]);
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            if (r <= i) begin
                tmp  = a[i];
                a[i] = a[r];
                a[r] = tmp;
                i--;
            end
            guard++;
        end
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(a[k]);
    endtask

    task automatic run_load(input logic m, input logic [15:0] s, input bit poke, input string tag);
        int   strobes;
        int   cyc;
        int   last_cyc;
        bit   fin;
        logic exp_lb;
        logic exp_lp;
        logic [31:0] exp_key;
        strobes  = 0;
        cyc      = 0;
        last_cyc = 0;
        fin      = 1'b0;
        exp_lb   = ~m;
        exp_lp   = m;
        exp_key  = m ? 32'hCAFEFACE : 32'hDEADBEEF;
        got_q.delete();
        @(negedge clk);
        mode  = m;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        seed  = 16'h5A5A;
        check({tag, " busy after start"}, {31'd0, busy}, 32'd1);
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (load_boxes || load_prisoners) begin
                check({tag, " load_boxes on strobe"}, {31'd0, load_boxes}, {31'd0, exp_lb});
                check({tag, " load_prisoners on strobe"}, {31'd0, load_prisoners}, {31'd0, exp_lp});
                check({tag, " select"}, {24'd0, select_v}, strobes);
                check({tag, " guard_key on strobe"}, guard_key, exp_key);
                if (strobes > 0) check({tag, " strobe spacing"}, cyc - last_cyc, 32'd2);
                got_q.push_back(data_v);
                strobes++;
                last_cyc = cyc;
            end else begin
                check({tag, " select between strobes"}, {24'd0, select_v}, 32'd0);
                check({tag, " data between strobes"}, {24'd0, data_v}, 32'd0);
                check({tag, " guard_key between strobes"}, guard_key, 32'd0);
            end
            check({tag, " perm_err"}, {31'd0, perm_err}, 32'd0);
            if (done) begin
                check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
                fin = 1'b1;
            end else begin
                check({tag, " busy while running"}, {31'd0, busy}, 32'd1);
            end
            start = poke && (cyc % 37 == 0);
            if (start) begin
                mode = ~m;
                seed = 16'(cyc);
            end
        end
        start = 1'b0;
        check({tag, " done seen"}, {31'd0, fin}, 32'd1);
        check({tag, " strobe count"}, strobes, N);
        @(negedge clk);
        check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
        check({tag, " back to idle"}, {29'd0, state_v}, 32'd0);
    endtask

    task automatic compare_seq(input string tag);
        bit dup_seen [256];
        int bad;
        check({tag, " sequence length"}, got_q.size(), N);
        bad = 0;
        for (int k = 0; k < 256; k++) dup_seen[k] = 1'b0;
        for (int k = 0; k < got_q.size() && k < N; k++) begin
            check({tag, " data vs model"}, {24'd0, got_q[k]}, {24'd0, exp_q[k]});
            if (got_q[k] == 8'd0 || got_q[k] > 8'(N) || dup_seen[got_q[k]]) bad++;
            dup_seen[got_q[k]] = 1'b1;
        end
        check({tag, " not a permutation of 1..N"}, bad, 0);
    endtask

    initial begin
        int strobes;
        int cyc;
        bit hit;

        repeat (3) @(negedge clk);
        check_idle_outputs("in reset");
        check("in reset state", {29'd0, state_v}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after reset");

        build_exp(16'h0001);
        run_load(1'b0, 16'h0001, 1'b0, "box");
        compare_seq("box");
        ref_q = got_q;

        run_load(1'b1, 16'h0001, 1'b0, "prisoner");
        compare_seq("prisoner");
        for (int k = 0; k < N && k < got_q.size(); k++)
            check("prisoner vs box data", {24'd0, got_q[k]}, {24'd0, ref_q[k]});

        build_exp(16'hACE1);
        run_load(1'b0, 16'h0000, 1'b1, "seed0 with starts");
        compare_seq("seed0 with starts");
        ref_q = got_q;
        run_load(1'b0, 16'hACE1, 1'b0, "seed ace1");
        for (int k = 0; k < N && k < got_q.size(); k++)
            check("seed0 vs ace1 data", {24'd0, got_q[k]}, {24'd0, ref_q[k]});

        // Reset at the 40th strobe, then a full reload from seed 1.
        @(negedge clk);
        mode  = 1'b0;
        seed  = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        strobes = 0;
        cyc     = 0;
        hit     = 1'b0;
        while (!hit && cyc < 20000) begin
            if (load_boxes) begin
                strobes++;
                if (strobes == 40) hit = 1'b1;
            end
            if (!hit) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("reached 40th strobe", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("async reset mid-load");
        check("async reset state", {29'd0, state_v}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        build_exp(16'h0001);
        run_load(1'b0, 16'h0001, 1'b0, "after reset");
        compare_seq("after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
